fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Control-side driver of the instruction-fetch PC interface. Produces Branch/Target/
//  Stall/done/exp_error, which the PC register samples on every CLK rising edge.
//  Arbitrates decode requests (halt, arithmetic exception, multi-cycle op, branch).
//  Sequences stall counts, exception redirects and halt through a small FSM.
// PARAMETERS
//  TGT_W    3  branch target index width; PC module shifts it left by 5
//  STALL_W  3  multi-cycle stall count width
// PORTS
//  CLK        in   1        clock; all state updates on the rising edge
//  Init_n     in   1        asynchronous, active-low reset
//  start      in   1        one-cycle pulse; moves the FSM from IDLE to RUN
//  br_req     in   1        decoded branch instruction
//  br_cond    in   1        branch condition flag; taken = br_req & br_cond
//  br_tgt     in   TGT_W    branch target index
//  mc_req     in   1        decoded multi-cycle op
//  mc_cycles  in   STALL_W  stall length for the multi-cycle op
//  ovf_pos    in   1        positive saturation detected
//  ovf_neg    in   1        negative saturation detected
//  halt_req   in   1        decoded halt instruction
//  Branch     out  1        redirect PC to Target this edge
//  Target     out  TGT_W    branch target index; valid only while Branch=1
//  Stall      out  1        hold PC
//  done       out  1        program finished; sticky
//  exp_error  out  2        01 = jump 256, 10 = jump 288, 00 = none
//  squash     out  1        discard the instruction in flight (feature only)
// BEHAVIOUR
//  FSM states: IDLE, RUN, STALL, EXC, HALT (+BUBBLE with the optional feature).
//  Reset (Init_n=0, async): state=IDLE, count=0.
//    Outputs at reset: Branch=0, Target=0, Stall=1, done=0, exp_error=00, squash=0.
//  IDLE: Stall=1, all requests ignored. start=1 -> RUN on the next edge.
//  RUN: requests are evaluated combinationally each cycle in this fixed priority:
//    1 halt_req -> HALT
//    2 ovf_pos|ovf_neg -> EXC; latch code 01 if ovf_pos (wins when both), else 10
//    3 mc_req -> STALL; count = (mc_cycles==0 ? 1 : mc_cycles)
//    4 br_req&br_cond -> Branch=1 and Target=br_tgt in the same cycle; stay in RUN
//    Lower-priority requests in the same cycle are dropped, not queued.
//    Branch is 1 only in RUN with no higher-priority request. Otherwise Branch=0, Target=0.
//  STALL: Stall=1 for exactly count cycles; count decrements each edge.
//    On the edge where count reaches 0 -> RUN. Requests in this state are ignored.
//  EXC: exp_error=latched code for exactly one cycle, Stall=0, Branch=0 -> RUN.
//  HALT: done=1, Stall=0, Branch=0, exp_error=00. Leaves HALT only on reset.
//  exp_error is registered: it is nonzero only in EXC and 00 in every other state.
//  A reset at any point, including mid-STALL or in EXC, aborts the state at once.
//  start outside IDLE is ignored.
// CONFIGURATION
//  BRANCH_BUBBLE_EN defined:
//    A taken branch in RUN moves the FSM to BUBBLE for one cycle.
//    In BUBBLE: Stall=1, squash=1, requests ignored -> RUN.
//  BRANCH_BUBBLE_EN undefined:
//    No BUBBLE state. squash is tied to 0 and a taken branch stays in RUN.
// TESTING
//  1 Reset then start pulse -> Stall=1 while IDLE; Stall=0 the cycle after start.
//  2 RUN, br_req=1 br_cond=1 br_tgt=3 -> Branch=1 Target=3 same cycle; PC=96 next edge.
//    Same with br_cond=0 -> Branch=0 and PC increments.
//  3 mc_req=1 mc_cycles=4 -> Stall=1 for exactly 4 cycles. mc_cycles=0 -> 1 cycle.
//    br_req asserted during the stall is ignored.
//  4 ovf_pos=ovf_neg=1 -> exp_error=01 for 1 cycle then PC=256.
//    ovf_neg alone -> exp_error=10 then PC=288.
//  5 halt_req together with br_req and ovf_pos -> done=1 and stays 1.
//    No Branch, exp_error=00. Init_n low clears done.
//  6 Init_n low mid-STALL (count=2) -> IDLE immediately with Stall=1.
//    With BRANCH_BUBBLE_EN: a taken branch gives squash=1 and Stall=1 for exactly 1 cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: arbitrates halt/exception/multi-cycle/branch requests
// and drives the PC interface. Optional post-branch bubble via `BRANCH_BUBBLE_EN.
module fetch_ctrl #(
    parameter int TGT_W   = 3,
    parameter int STALL_W = 3
) (
    input  logic               CLK,
    input  logic               Init_n,
    input  logic               start,
    input  logic               br_req,
    input  logic               br_cond,
    input  logic [TGT_W-1:0]   br_tgt,
    input  logic               mc_req,
    input  logic [STALL_W-1:0] mc_cycles,
    input  logic               ovf_pos,
    input  logic               ovf_neg,
    input  logic               halt_req,
    output logic               Branch,
    output logic [TGT_W-1:0]   Target,
    output logic               Stall,
    output logic               done,
    output logic [1:0]         exp_error,
    output logic               squash
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STALL  = 3'd2;
    localparam logic [2:0] S_EXC    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
`ifdef BRANCH_BUBBLE_EN
    localparam logic [2:0] S_BUBBLE = 3'd5;
`endif

    localparam logic [STALL_W-1:0] CNT_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    logic [2:0]         state, state_nxt;
    logic [STALL_W-1:0] count, count_nxt;
    logic [1:0]         err_q, err_nxt;
    logic               taken;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        err_nxt   = 2'b00;
        taken     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Fixed priority; anything below the winner is dropped this cycle.
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (ovf_pos || ovf_neg) begin
                    state_nxt = S_EXC;
                    err_nxt   = ovf_pos ? 2'b01 : 2'b10;
                end else if (mc_req) begin
                    state_nxt = S_STALL;
                    count_nxt = (mc_cycles == '0) ? CNT_ONE : mc_cycles;
                end else if (br_req && br_cond) begin
                    taken = 1'b1;
`ifdef BRANCH_BUBBLE_EN
                    state_nxt = S_BUBBLE;
`endif
                end
            end
            S_STALL: begin
                count_nxt = count - CNT_ONE;
                if (count <= CNT_ONE) begin
                    count_nxt = '0;
                    state_nxt = S_RUN;
                end
            end
            S_EXC:    state_nxt = S_RUN;
            S_HALT:   state_nxt = S_HALT;
`ifdef BRANCH_BUBBLE_EN
            S_BUBBLE: state_nxt = S_RUN;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state <= S_IDLE;
            count <= '0;
            err_q <= 2'b00;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            err_q <= err_nxt;
        end
    end

    assign Branch    = taken;
    assign Target    = taken ? br_tgt : '0;
    assign done      = (state == S_HALT);
    assign exp_error = err_q;

`ifdef BRANCH_BUBBLE_EN
    assign Stall  = (state == S_IDLE) || (state == S_STALL) || (state == S_BUBBLE);
    assign squash = (state == S_BUBBLE);
`else
    assign Stall  = (state == S_IDLE) || (state == S_STALL);
    assign squash = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, each cycle
// compared against a flag/counter reference model plus a simple PC model.
module tb_fetch_ctrl;
    localparam int TGT_W   = 3;
    localparam int STALL_W = 3;
`ifdef BRANCH_BUBBLE_EN
    localparam bit BUB = 1'b1;
`else
    localparam bit BUB = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               Init_n, start, br_req, br_cond, mc_req, ovf_pos, ovf_neg, halt_req;
    logic [TGT_W-1:0]   br_tgt;
    logic [STALL_W-1:0] mc_cycles;
    logic               Branch, Stall, done, squash;
    logic [TGT_W-1:0]   Target;
    logic [1:0]         exp_error;

    fetch_ctrl #(.TGT_W(TGT_W), .STALL_W(STALL_W)) dut (
        .CLK(CLK), .Init_n(Init_n), .start(start), .br_req(br_req), .br_cond(br_cond),
        .br_tgt(br_tgt), .mc_req(mc_req), .mc_cycles(mc_cycles), .ovf_pos(ovf_pos),
        .ovf_neg(ovf_neg), .halt_req(halt_req), .Branch(Branch), .Target(Target),
        .Stall(Stall), .done(done), .exp_error(exp_error), .squash(squash)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain flags and counters describing what the block is doing.
    bit m_started, m_halted, m_bubble;
    int m_stall_left, m_exc;

    // PC as the downstream register would see it.
    int pc;
    always @(posedge CLK or negedge Init_n) begin
        if (!Init_n)                 pc <= 0;
        else if (Branch)             pc <= int'(Target) * 32;
        else if (exp_error == 2'b01) pc <= 256;
        else if (exp_error == 2'b10) pc <= 288;
        else if (!Stall)             pc <= pc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_bubble = 0; m_stall_left = 0; m_exc = 0;
    endtask

    task automatic compare_outputs(input string tag);
        bit busy, e_br;
        int e_stall;
        busy = m_halted || !m_started || (m_stall_left > 0) || (m_exc != 0) || m_bubble;
        e_br = !busy && !halt_req && !ovf_pos && !ovf_neg && !mc_req && br_req && br_cond;
        e_stall = m_halted ? 0 : ((!m_started || m_stall_left > 0 || m_bubble) ? 1 : 0);
        check({tag, ".Branch"}, int'(Branch), int'(e_br));
        check({tag, ".Target"}, int'(Target), e_br ? int'(br_tgt) : 0);
        check({tag, ".Stall"},  int'(Stall), e_stall);
        check({tag, ".done"},   int'(done), int'(m_halted));
        check({tag, ".exp_error"}, int'(exp_error), m_exc);
        check({tag, ".squash"}, int'(squash), int'(m_bubble));
    endtask

    task automatic model_edge();
        if (m_halted) begin
        end else if (!m_started) begin
            if (start) m_started = 1;
        end else if (m_stall_left > 0) begin
            m_stall_left--;
        end else if (m_exc != 0) begin
            m_exc = 0;
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (halt_req) begin
            m_halted = 1;
        end else if (ovf_pos || ovf_neg) begin
            m_exc = ovf_pos ? 1 : 2;
        end else if (mc_req) begin
            m_stall_left = (mc_cycles == 0) ? 1 : int'(mc_cycles);
        end else if (br_req && br_cond && BUB) begin
            m_bubble = 1;
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        if (!Init_n) model_reset();
        #1;
        compare_outputs(tag);
        @(posedge CLK);
        if (Init_n) model_edge();
        @(negedge CLK);
    endtask

    task automatic clear_req();
        start = 0; br_req = 0; br_cond = 0; br_tgt = '0; mc_req = 0;
        mc_cycles = '0; ovf_pos = 0; ovf_neg = 0; halt_req = 0;
    endtask

    initial begin
        clear_req();
        Init_n = 0;
        model_reset();
        @(negedge CLK);
        step("reset");
        Init_n = 1;
        step("idle");
        br_req = 1; br_cond = 1; br_tgt = 3'd5;
        step("idle_ignores_br");
        clear_req();
        start = 1; step("start"); start = 0;
        check("pc_after_start", pc, 0);

        br_req = 1; br_cond = 1; br_tgt = 3'd3;
        step("br_taken");
        check("pc_branch96", pc, 96);
        clear_req();
        if (BUB) step("bubble");
        br_req = 1; br_cond = 0; br_tgt = 3'd6;
        step("br_not_taken");
        check("pc_incr", pc, BUB ? 97 : 97);

        clear_req(); mc_req = 1; mc_cycles = 3'd4;
        step("mc4_req");
        clear_req(); br_req = 1; br_cond = 1; br_tgt = 3'd2;
        repeat (4) step("mc4_stall");
        clear_req();
        step("mc4_run");
        mc_req = 1; mc_cycles = 3'd0;
        step("mc0_req");
        clear_req();
        step("mc0_stall");
        step("mc0_run");

        ovf_pos = 1; ovf_neg = 1; br_req = 1; br_cond = 1;
        step("ovf_both");
        clear_req();
        step("exc01");
        check("pc_exc256", pc, 256);
        ovf_neg = 1;
        step("ovf_neg");
        clear_req();
        step("exc10");
        check("pc_exc288", pc, 288);

        mc_req = 1; mc_cycles = 3'd3;
        step("mc3_req");
        clear_req();
        step("mc3_stall");
        Init_n = 0;
        step("reset_mid_stall");
        Init_n = 1;
        start = 1; step("restart"); start = 0;

        halt_req = 1; br_req = 1; br_cond = 1; ovf_pos = 1;
        step("halt_req");
        clear_req(); start = 1; br_req = 1; br_cond = 1; ovf_neg = 1;
        repeat (3) step("halted");
        clear_req();
        Init_n = 0;
        step("reset_clears_done");
        Init_n = 1;

        for (int i = 0; i < 3000; i++) begin
            Init_n    = ($urandom_range(0, 119) != 0);
            start     = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 63) == 0);
            ovf_pos   = ($urandom_range(0, 15) == 0);
            ovf_neg   = ($urandom_range(0, 15) == 0);
            mc_req    = ($urandom_range(0, 7) == 0);
            mc_cycles = STALL_W'($urandom);
            br_req    = $urandom_range(0, 1) != 0;
            br_cond   = $urandom_range(0, 1) != 0;
            br_tgt    = TGT_W'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
